// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the I/O port
//   tx_state_t  - serial transmitter states
//   DATA_W      - bus / frame data width
//   START_BIT / STOP_BIT - line levels for the frame delimiters
package io_pkg;
  localparam int DATA_W = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with sticky overflow
//   i_clk, i_nReset - clock, async active-low reset
//   i_push, i_data  - write request and data (dropped when full unless popped)
//   i_pop, o_data   - read request and head-of-queue data (show-ahead)
//   o_full, o_empty, o_overflow - status; overflow is sticky until reset
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = DATA_W
) (
  input  logic         i_clk,
  input  logic         i_nReset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wrPtr, rdPtr;
  logic [W-1:0] mem [DEPTH];
  logic doPop, doPush;
  assign o_empty = wrPtr == rdPtr;
  assign o_full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop = i_pop && !o_empty;
  // a pop in the same cycle frees a slot, so a push onto a full FIFO still lands
  assign doPush = i_push && (!o_full || doPop);
  assign o_data = mem[rdPtr[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_nReset)
    if (!i_nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (i_push && !doPush) o_overflow <= 1'b1;
    end
  always_ff @(posedge i_clk)
    if (doPush) mem[wrPtr[AW-1:0]] <= i_data;
endmodule

// File: rtl/io_port.sv
// io_port: bus-side I/O responder - output FIFO to 8N1 serial, strobed input register
//   i_clk, i_nReset         - clock, async active-low reset
//   i_bus, i_ctrlWrOut      - bus byte and write strobe into the output FIFO
//   i_ctrlInNoe, o_bus, o_busEn - active-low read enable, input byte onto bus
//   i_inData, i_inStrobe    - external byte and capture pulse
//   o_tx                    - serial line, idle high
//   o_outFull, o_outEmpty, o_inValid, o_outOverflow, o_inOverflow - status
module io_port
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_nReset,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_ctrlWrOut,
  input  logic              i_ctrlInNoe,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_busEn,
  input  logic [DATA_W-1:0] i_inData,
  input  logic              i_inStrobe,
  output logic              o_tx,
  output logic              o_outFull,
  output logic              o_outEmpty,
  output logic              o_inValid,
  output logic              o_outOverflow,
  output logic              o_inOverflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);
  tx_state_t state, nextState;
  logic [BW-1:0] baud;
  logic [2:0] bitCnt;
  logic [DATA_W-1:0] shiftReg, fifoData, inReg;
  logic pop, baudZero, fifoEmpty, readClr, capture;
  io_fifo #(.DEPTH(DEPTH), .W(DATA_W)) uFifo (
    .i_clk(i_clk), .i_nReset(i_nReset), .i_push(i_ctrlWrOut), .i_data(i_bus),
    .i_pop(pop), .o_data(fifoData), .o_full(o_outFull), .o_empty(fifoEmpty),
    .o_overflow(o_outOverflow)
  );
  assign baudZero = baud == '0;
  always_ff @(posedge i_clk or negedge i_nReset)
    if (!i_nReset) begin
      state <= IDLE;
      baud <= RELOAD;
      bitCnt <= '0;
      shiftReg <= '0;
    end else begin
      state <= nextState;
      // every state entry comes either from IDLE or from a baud expiry, so this reloads on entry
      baud <= (state == IDLE || baudZero) ? RELOAD : baud - 1'b1;
      bitCnt <= (state == DATA) ? bitCnt + 3'(baudZero) : 3'd0;
      if (pop) shiftReg <= fifoData;
      else if (state == DATA && baudZero) shiftReg <= shiftReg >> 1;
    end
  always_comb begin
    nextState = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        nextState = fifoEmpty ? IDLE : START;
        pop = !fifoEmpty;
      end
      START: nextState = baudZero ? DATA : START;
      DATA: nextState = (baudZero && bitCnt == 3'd7) ? STOP : DATA;
      STOP: if (baudZero) begin
        nextState = fifoEmpty ? IDLE : START;
        pop = !fifoEmpty;
      end
      default: nextState = IDLE;
    endcase
  end
  always_comb begin
    o_tx = state == START ? START_BIT : state == DATA ? shiftReg[0] : STOP_BIT;
    o_outEmpty = fifoEmpty && state == IDLE;
  end
  // a read and a strobe on the same edge hand the register straight to the new byte
  assign readClr = o_inValid && !i_ctrlInNoe;
  assign capture = i_inStrobe && (!o_inValid || readClr);
  always_ff @(posedge i_clk or negedge i_nReset)
    if (!i_nReset) begin
      inReg <= '0;
      o_inValid <= 1'b0;
      o_inOverflow <= 1'b0;
    end else begin
      if (capture) inReg <= i_inData;
      o_inValid <= capture || (o_inValid && !readClr);
      o_inOverflow <= o_inOverflow || (i_inStrobe && o_inValid && !readClr);
    end
  assign o_busEn = ~i_ctrlInNoe;
  assign o_bus = i_ctrlInNoe ? '0 : inReg;
endmodule
